pack13x39: RTL

Downstream reassembly stage for the 39-to-13 serializer: collects three consecutive 13-bit words from the serial link, rebuilds the original 39-bit word, and presents it on a registered valid/ready output. Framing uses a first-word marker. Partial or misaligned groups are dropped and counted.

---
 rtl/pack13x39_if.sv | 21 ++
 rtl/pack13x39.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pack13x39_if.sv
// Word-stream handshake bundle for pack13x39: 13-bit serial input side and
// registered 39-bit output side, each with valid/ready.
interface pack13x39_if;
    logic [12:0] dataIn;
    logic        validIn;
    logic        frameIn;
    logic        readyOut;
    logic [38:0] dataOut;
    logic        validOut;
    logic        readyIn;

    modport master (
        output dataIn, validIn, frameIn, readyIn,
        input  readyOut, dataOut, validOut
    );

    modport slave (
        input  dataIn, validIn, frameIn, readyIn,
        output readyOut, dataOut, validOut
    );
endinterface

// File: rtl/pack13x39.sv
// Reassembles three framed 13-bit words into one 39-bit word with a registered
// valid/ready output. Optional parity output: define PACK13X39_PARITY_EN.
module pack13x39 (
    input  logic        clkIn,
    input  logic        rstnIn,
    pack13x39_if.slave  bus,
    output logic [7:0]  errCntOut,
    output logic        parityOut
);
    localparam int DATA_W = 13;

    typedef enum logic [1:0] {W0, W1, W2} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic signed [DATA_W-1:0]   r_word0_p0;
    logic signed [DATA_W-1:0]   r_word1_p0;
    logic [3*DATA_W-1:0]        r_data_p1;
    logic                       r_vld_p1;
    logic [7:0]                 r_err;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_drain;
    logic                       w_load0;
    logic                       w_load1;
    logic                       w_load_out;
    logic                       w_err;
    logic [3*DATA_W-1:0]        w_full;

    // Only the completing word in W2 can stall, and only while the output is full and held.
    assign w_ready    = (r_state != W2) || !r_vld_p1 || bus.readyIn;
    assign w_accept   = bus.validIn && w_ready;
    assign w_drain    = r_vld_p1 && bus.readyIn;
    assign w_full     = {r_word0_p0, r_word1_p0, bus.dataIn};

    always_comb begin
        w_state_nxt = r_state;
        w_load0     = 1'b0;
        w_load1     = 1'b0;
        w_load_out  = 1'b0;
        w_err       = 1'b0;
        if (w_accept) begin
            case (r_state)
                W0: begin
                    if (bus.frameIn) begin
                        w_load0     = 1'b1;
                        w_state_nxt = W1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                W1: begin
                    if (bus.frameIn) begin
                        w_err       = 1'b1;
                        w_load0     = 1'b1;
                        w_state_nxt = W1;
                    end else begin
                        w_load1     = 1'b1;
                        w_state_nxt = W2;
                    end
                end
                W2: begin
                    if (bus.frameIn) begin
                        w_err       = 1'b1;
                        w_load0     = 1'b1;
                        w_state_nxt = W1;
                    end else begin
                        w_load_out  = 1'b1;
                        w_state_nxt = W0;
                    end
                end
                default: w_state_nxt = W0;
            endcase
        end
    end

    // Stage p0: FSM and partial-word capture
    always_ff @(posedge clkIn or negedge rstnIn) begin
        if (!rstnIn) begin
            r_state    <= W0;
            r_word0_p0 <= '0;
            r_word1_p0 <= '0;
            r_err      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load0) r_word0_p0 <= bus.dataIn;
            if (w_load1) r_word1_p0 <= bus.dataIn;
            if (w_err && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
        end
    end

    // Stage p1: output register; a load wins over a same-cycle drain
    always_ff @(posedge clkIn or negedge rstnIn) begin
        if (!rstnIn) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_data_p1 <= w_full;
                r_vld_p1  <= 1'b1;
            end else if (w_drain) begin
                r_vld_p1  <= 1'b0;
            end
        end
    end

`ifdef PACK13X39_PARITY_EN
    function automatic logic f_even_parity(input logic [3*DATA_W-1:0] d);
        return ^d;
    endfunction

    logic r_par_p1;

    always_ff @(posedge clkIn or negedge rstnIn) begin
        if (!rstnIn) begin
            r_par_p1 <= 1'b0;
        end else if (w_load_out) begin
            r_par_p1 <= f_even_parity(w_full);
        end
    end

    assign parityOut = r_par_p1;
`else
    assign parityOut = 1'b0;
`endif

    assign bus.readyOut = w_ready;
    assign bus.dataOut  = r_data_p1;
    assign bus.validOut = r_vld_p1;
    assign errCntOut    = r_err;

endmodule
